// File: rtl/hazard_scoreboard.sv
// Destination-tag pipeline (EXE/MEM/WB) feeding the forwarding selector, plus
// the ID-stage stall for hazards that forwarding cannot cover.
module hazard_scoreboard #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_uses_src1,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic             fwd_en,
    input  logic             branch_taken,
    output logic             hazard_stall,
    output logic [REG_W-1:0] exe_dest,
    output logic             exe_wb_en,
    output logic             exe_mem_read,
    output logic [REG_W-1:0] mem_dest,
    output logic             mem_wb_en,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_wb_en,
    output logic [CNT_W-1:0] stall_count
);

    logic [REG_W-1:0] exe_dest_reg, exe_dest_next;
    logic             exe_wb_en_reg, exe_wb_en_next;
    logic             exe_mem_read_reg, exe_mem_read_next;
    logic [REG_W-1:0] mem_dest_reg, wb_dest_reg;
    logic             mem_wb_en_reg, wb_wb_en_reg;
    logic [CNT_W-1:0] stall_count_reg, stall_count_next;

    // Index 0 = EXE, 1 = MEM; WB never stalls because the register file
    // writes in the first half of the cycle and reads in the second.
    logic [REG_W-1:0] tag_dest [2];
    logic             tag_wb_en [2];
    logic [1:0]       hit;

    assign tag_dest[0]  = exe_dest_reg;
    assign tag_dest[1]  = mem_dest_reg;
    assign tag_wb_en[0] = exe_wb_en_reg;
    assign tag_wb_en[1] = mem_wb_en_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_match
            assign hit[gi] = tag_wb_en[gi] &
                             ((id_uses_src1 & (id_src1 == tag_dest[gi])) |
                              (id_two_src   & (id_src2 == tag_dest[gi])));
        end
    endgenerate

    always_comb begin
        hazard_stall = 1'b0;
        if (id_valid && !branch_taken) begin
            if (fwd_en)
                hazard_stall = hit[0] & exe_mem_read_reg;
            else
                hazard_stall = hit[0] | hit[1];
        end
    end

    always_comb begin
        exe_dest_next     = '0;
        exe_wb_en_next    = 1'b0;
        exe_mem_read_next = 1'b0;
        // Flush and stall both inject a bubble; only a clean valid ID advances.
        if (!branch_taken && !hazard_stall && id_valid) begin
            exe_dest_next     = id_dest;
            exe_wb_en_next    = id_wb_en;
            exe_mem_read_next = id_mem_read;
        end
        stall_count_next = stall_count_reg;
        if (hazard_stall && (stall_count_reg != '1))
            stall_count_next = stall_count_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_dest_reg     <= '0;
            exe_wb_en_reg    <= 1'b0;
            exe_mem_read_reg <= 1'b0;
            mem_dest_reg     <= '0;
            mem_wb_en_reg    <= 1'b0;
            wb_dest_reg      <= '0;
            wb_wb_en_reg     <= 1'b0;
            stall_count_reg  <= '0;
        end else begin
            exe_dest_reg     <= exe_dest_next;
            exe_wb_en_reg    <= exe_wb_en_next;
            exe_mem_read_reg <= exe_mem_read_next;
            mem_dest_reg     <= exe_dest_reg;
            mem_wb_en_reg    <= exe_wb_en_reg;
            wb_dest_reg      <= mem_dest_reg;
            wb_wb_en_reg     <= mem_wb_en_reg;
            stall_count_reg  <= stall_count_next;
        end
    end

    assign exe_dest     = exe_dest_reg;
    assign exe_wb_en    = exe_wb_en_reg;
    assign exe_mem_read = exe_mem_read_reg;
    assign mem_dest     = mem_dest_reg;
    assign mem_wb_en    = mem_wb_en_reg;
    assign wb_dest      = wb_dest_reg;
    assign wb_wb_en     = wb_wb_en_reg;
    assign stall_count  = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: the driver queues hand-computed expectations tagged with a
// cycle number; the monitor pops and compares them on the falling edge.
module tb_hazard_scoreboard;

    localparam int REG_W = 4;
    localparam int CNT_W = 4;

    localparam int F_STALL = 0, F_EXE_DEST = 1, F_EXE_WB = 2, F_EXE_MR = 3,
                   F_MEM_DEST = 4, F_MEM_WB = 5, F_WB_DEST = 6, F_WB_WB = 7,
                   F_CNT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_src1, id_src2, id_dest;
    logic             id_uses_src1, id_two_src, id_wb_en, id_mem_read;
    logic             fwd_en, branch_taken;
    logic             hazard_stall;
    logic [REG_W-1:0] exe_dest, mem_dest, wb_dest;
    logic             exe_wb_en, exe_mem_read, mem_wb_en, wb_wb_en;
    logic [CNT_W-1:0] stall_count;

    hazard_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_uses_src1(id_uses_src1), .id_two_src(id_two_src),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .fwd_en(fwd_en), .branch_taken(branch_taken), .hazard_stall(hazard_stall),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest),
        .wb_wb_en(wb_wb_en), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string name;
        int    field;
        int    val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc++;

    function automatic int field_val(int f);
        case (f)
            F_STALL:    return int'(hazard_stall);
            F_EXE_DEST: return int'(exe_dest);
            F_EXE_WB:   return int'(exe_wb_en);
            F_EXE_MR:   return int'(exe_mem_read);
            F_MEM_DEST: return int'(mem_dest);
            F_MEM_WB:   return int'(mem_wb_en);
            F_WB_DEST:  return int'(wb_dest);
            F_WB_WB:    return int'(wb_wb_en);
            default:    return int'(stall_count);
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        int   act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = field_val(e.field);
            tests++;
            if (act !== e.val || e.cyc != cyc) begin
                fails++;
                $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", e.name, cyc, act, e.val);
            end else begin
                $display("[TB] ok   %s cyc=%0d value=%0d", e.name, cyc, act);
            end
        end
    end

    task automatic chk(string name, int f, int v);
        exp_t e;
        e.cyc = cyc; e.name = name; e.field = f; e.val = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(logic v, logic [REG_W-1:0] s1, logic u1,
                          logic [REG_W-1:0] s2, logic two,
                          logic [REG_W-1:0] d, logic wb, logic mr);
        id_valid = v; id_src1 = s1; id_uses_src1 = u1; id_src2 = s2;
        id_two_src = two; id_dest = d; id_wb_en = wb; id_mem_read = mr;
    endtask

    task automatic idle();
        set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; fwd_en = 1'b1; branch_taken = 1'b0;
        // Reset with a live writing instruction that reads R0.
        set_id(1'b1, 0, 1'b1, 0, 1'b1, 7, 1'b1, 1'b0);
        tick(); tick();
        chk("rst_stall", F_STALL, 0);     chk("rst_exe_dest", F_EXE_DEST, 0);
        chk("rst_exe_wb", F_EXE_WB, 0);   chk("rst_exe_mr", F_EXE_MR, 0);
        chk("rst_mem_dest", F_MEM_DEST, 0); chk("rst_mem_wb", F_MEM_WB, 0);
        chk("rst_wb_dest", F_WB_DEST, 0); chk("rst_wb_wb", F_WB_WB, 0);
        chk("rst_cnt", F_CNT, 0);
        rst = 1'b1;
        idle(); tick();

        // Load-use with forwarding: exactly one stall cycle.
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1);
        chk("lu_load_nostall", F_STALL, 0);
        tick();
        set_id(1'b1, 3, 1'b1, 0, 1'b0, 4, 1'b1, 1'b0);
        chk("lu_stall", F_STALL, 1);  chk("lu_exe_dest", F_EXE_DEST, 3);
        chk("lu_exe_mr", F_EXE_MR, 1); chk("lu_exe_wb", F_EXE_WB, 1);
        tick();
        chk("lu_release", F_STALL, 0); chk("lu_mem_dest", F_MEM_DEST, 3);
        chk("lu_mem_wb", F_MEM_WB, 1);  chk("lu_bubble", F_EXE_WB, 0);
        chk("lu_cnt", F_CNT, 1);
        tick();
        idle();
        chk("lu_reader_exe", F_EXE_DEST, 4); chk("lu_reader_wb", F_EXE_WB, 1);
        chk("lu_wb_dest", F_WB_DEST, 3);      chk("lu_wb_wb", F_WB_WB, 1);
        tick(); drain();

        // ALU RAW with forwarding: no stall.
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 0, 1'b0, 5, 1'b1, 6, 1'b1, 1'b0);
        chk("alu_fwd_nostall", F_STALL, 0); chk("alu_exe_dest", F_EXE_DEST, 5);
        tick();
        idle();
        chk("alu_mem_dest", F_MEM_DEST, 5); chk("alu_mem_wb", F_MEM_WB, 1);
        chk("alu_reader_exe", F_EXE_DEST, 6); chk("alu_cnt", F_CNT, 1);
        tick(); drain();

        // ALU RAW without forwarding: two stall cycles.
        fwd_en = 1'b0;
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);
        chk("nf_stall1", F_STALL, 1); chk("nf_exe_dest", F_EXE_DEST, 5);
        tick();
        chk("nf_stall2", F_STALL, 1); chk("nf_mem_dest", F_MEM_DEST, 5);
        chk("nf_bubble", F_EXE_WB, 0); chk("nf_cnt1", F_CNT, 2);
        tick();
        chk("nf_release", F_STALL, 0); chk("nf_wb_dest", F_WB_DEST, 5);
        chk("nf_wb_wb", F_WB_WB, 1);    chk("nf_cnt2", F_CNT, 3);
        tick();
        idle();
        chk("nf_reader_exe", F_EXE_DEST, 8); chk("nf_reader_wb", F_EXE_WB, 1);
        tick(); drain();

        // A dest with wb_en=0 is never a hazard.
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 9, 1'b1, 9, 1'b1, 1, 1'b1, 1'b0);
        chk("nowb_nostall", F_STALL, 0);
        tick(); drain();
        fwd_en = 1'b1;

        // Flush beats a load-use hazard.
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 2, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0);
        branch_taken = 1'b1;
        chk("flush_nostall", F_STALL, 0);
        tick();
        branch_taken = 1'b0;
        idle();
        chk("flush_exe_wb", F_EXE_WB, 0); chk("flush_exe_dest", F_EXE_DEST, 0);
        chk("flush_mem_dest", F_MEM_DEST, 2); chk("flush_cnt", F_CNT, 3);
        tick(); drain();

        // Register 0 is an ordinary register (load R0, then read via src2).
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
        chk("r0_stall", F_STALL, 1);
        tick();
        chk("r0_cnt", F_CNT, 4);
        tick(); drain();

        // Saturation: 20 load-use stalls on a 4-bit counter.
        rst = 1'b0; tick(); rst = 1'b1;
        chk("sat_rst_cnt", F_CNT, 0);
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b1);
            chk($sformatf("sat_cnt_%0d", i), F_CNT, (i < 15) ? i : 15);
            tick();
            set_id(1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
            chk($sformatf("sat_stall_%0d", i), F_STALL, 1);
            tick();
        end
        idle();
        chk("sat_hold", F_CNT, 15);
        tick(); drain();

        // Reset wins while a stall is being asserted.
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle();
        chk("midrst_cnt", F_CNT, 0); chk("midrst_mem_wb", F_MEM_WB, 0);
        chk("midrst_exe_wb", F_EXE_WB, 0);
        tick(); tick();

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("[TB] FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
